// File: rtl/dmem_if.sv
// Load/store handshake between the CPU MEM stage and the data-memory responder.
interface dmem_if;
    logic        req_i;
    logic        we_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        stall_o;

    // CPU side: issues requests, observes completion and stall
    modport master (
        output req_i, we_i, addr_i, wdata_i,
        input  ready_o, ack_o, rdata_o, err_o, stall_o
    );

    // Memory side: accepts requests, returns completion and stall
    modport slave (
        input  req_i, we_i, addr_i, wdata_i,
        output ready_o, ack_o, rdata_o, err_o, stall_o
    );
endinterface

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: req/ack handshake with fixed access
// latency, pipeline stall, and misaligned/out-of-range error reporting.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 4
) (
    input  logic clk_i,
    input  logic rst_i,
    dmem_if.slave bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               we_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [31:0]        rdata_q, rdata_d;
    logic               ready_q;
    logic               latch_en;

    logic [31:0]        mem [DEPTH_WORDS];

    // With LATENCY==1 the response is formed on the acceptance edge, so the
    // access attributes come straight from the bus while still in IDLE.
    logic               acc_we;
    logic [31:0]        acc_addr;
    logic [IDX_W-1:0]   acc_idx;
    logic               acc_err;
    logic               commit;

    // Select live or latched request and classify it
    always_comb begin
        acc_we   = (state == IDLE) ? bus.we_i   : we_q;
        acc_addr = (state == IDLE) ? bus.addr_i : addr_q;
        acc_idx  = acc_addr[IDX_W+1:2];
        acc_err  = (acc_addr[1:0] != 2'b00) || ((acc_addr >> 2) >= 32'(DEPTH_WORDS));
    end

    // Next-state, counter and response formation
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        ack_d    = 1'b0;
        err_d    = 1'b0;
        rdata_d  = 32'h0;
        latch_en = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req_i) begin
                    latch_en = 1'b1;
                    cnt_d    = CNT_W'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = RESP;
                        ack_d   = 1'b1;
                        err_d   = acc_err;
                        rdata_d = (!acc_we && !acc_err) ? mem[acc_idx] : 32'h0;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt == CNT_W'(1)) begin
                    state_d = RESP;
                    ack_d   = 1'b1;
                    err_d   = acc_err;
                    rdata_d = (!acc_we && !acc_err) ? mem[acc_idx] : 32'h0;
                end else begin
                    cnt_d = cnt - CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, counter and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            rdata_q <= 32'h0;
            ready_q <= 1'b1;
        end else begin
            state   <= state_d;
            cnt     <= cnt_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            rdata_q <= rdata_d;
            ready_q <= (state_d == IDLE);
        end
    end

    // Request capture on acceptance
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
        end else if (latch_en) begin
            we_q    <= bus.we_i;
            addr_q  <= bus.addr_i;
            wdata_q <= bus.wdata_i;
        end
    end

    // Stores commit on the edge leaving RESP; errored stores are dropped
    assign commit = (state == RESP) && we_q && !err_q;

    // Memory array write port (contents survive reset)
    always_ff @(posedge clk_i) begin
        if (!rst_i && commit) begin
            mem[addr_q[IDX_W+1:2]] <= wdata_q;
        end
    end

    assign bus.ready_o = ready_q;
    assign bus.ack_o   = ack_q;
    assign bus.err_o   = err_q;
    assign bus.rdata_o = rdata_q;
    assign bus.stall_o = bus.req_i & ~ack_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=4 and LATENCY=1 instances.
module tb_dmem_responder;

    logic clk;
    logic rst;
    int   vectors;
    int   miscompares;

    dmem_if bus4 ();
    dmem_if bus1 ();

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(4)) u_dut4 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus4)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive request lines of the selected instance (sel=1 -> LATENCY=1 DUT)
    task automatic drive(input bit sel, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
        if (sel) begin
            bus1.req_i = req; bus1.we_i = we; bus1.addr_i = addr; bus1.wdata_i = wdata;
        end else begin
            bus4.req_i = req; bus4.we_i = we; bus4.addr_i = addr; bus4.wdata_i = wdata;
        end
    endtask

    // Issue one access starting in an IDLE cycle (cycle 0) and record what happens
    task automatic access(input bit sel, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int ack_cyc,
                          output logic [31:0] rd, output logic er,
                          output logic [15:0] stall_tr, output logic [15:0] ready_tr);
        bit done;
        done     = 1'b0;
        ack_cyc  = -1;
        rd       = 32'h0;
        er       = 1'b0;
        stall_tr = '0;
        ready_tr = '0;
        drive(sel, 1'b1, we, addr, wdata);
        for (int n = 0; n < 16 && !done; n++) begin
            @(negedge clk);
            stall_tr[n] = sel ? bus1.stall_o : bus4.stall_o;
            ready_tr[n] = sel ? bus1.ready_o : bus4.ready_o;
            if (sel ? bus1.ack_o : bus4.ack_o) begin
                ack_cyc = n;
                rd      = sel ? bus1.rdata_o : bus4.rdata_o;
                er      = sel ? bus1.err_o : bus4.err_o;
                done    = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        drive(sel, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1'b1, 1'b1, 1'b0, 32'h10, 32'h0);
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        vectors++;
        if (bus4.ready_o !== 1'b1) begin
            miscompares++; $display("FAIL reset_ready: got %b expected 1", bus4.ready_o);
        end
        vectors++;
        if (bus4.ack_o !== 1'b0 || bus4.err_o !== 1'b0) begin
            miscompares++; $display("FAIL reset_ack_err: got ack=%b err=%b expected 0 0", bus4.ack_o, bus4.err_o);
        end
        vectors++;
        if (bus4.rdata_o !== 32'h0) begin
            miscompares++; $display("FAIL reset_rdata: got %h expected 00000000", bus4.rdata_o);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        vectors++;
        if (bus4.ready_o !== 1'b1 || bus1.ready_o !== 1'b1) begin
            miscompares++; $display("FAIL reset_no_accept: got ready4=%b ready1=%b expected 1 1", bus4.ready_o, bus1.ready_o);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store_load();
        int ac; logic [31:0] rd; logic er; logic [15:0] st, rt;
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ac, rd, er, st, rt);
        vectors++;
        if (ac !== 4) begin miscompares++; $display("FAIL store_ack_cycle: got %0d expected 4", ac); end
        vectors++;
        if (er !== 1'b0 || rd !== 32'h0) begin
            miscompares++; $display("FAIL store_resp: got err=%b rdata=%h expected 0 00000000", er, rd);
        end
        vectors++;
        if (st[4:0] !== 5'b01111) begin
            miscompares++; $display("FAIL store_stall: got %b expected 01111", st[4:0]);
        end
        access(1'b0, 1'b0, 32'h10, 32'h0, ac, rd, er, st, rt);
        vectors++;
        if (ac !== 4) begin miscompares++; $display("FAIL load_ack_cycle: got %0d expected 4", ac); end
        vectors++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            miscompares++; $display("FAIL load_rdata: got %h err=%b expected deadbeef 0", rd, er);
        end
        vectors++;
        if (st[4:0] !== 5'b01111) begin
            miscompares++; $display("FAIL load_stall: got %b expected 01111", st[4:0]);
        end
        vectors++;
        if (rt[4:0] !== 5'b00001) begin
            miscompares++; $display("FAIL load_ready: got %b expected 00001", rt[4:0]);
        end
        access(1'b0, 1'b1, 32'h00, 32'h0BADF00D, ac, rd, er, st, rt);
        access(1'b0, 1'b0, 32'h00, 32'h0, ac, rd, er, st, rt);
        vectors++;
        if (rd !== 32'h0BADF00D) begin
            miscompares++; $display("FAIL load_word0: got %h expected 0badf00d", rd);
        end
    endtask

    task automatic test_errors();
        int ac; logic [31:0] rd; logic er; logic [15:0] st, rt;
        access(1'b0, 1'b0, 32'h13, 32'h0, ac, rd, er, st, rt);
        vectors++;
        if (ac !== 4 || er !== 1'b1 || rd !== 32'h0) begin
            miscompares++; $display("FAIL err_misaligned_load: got cyc=%0d err=%b rdata=%h expected 4 1 00000000", ac, er, rd);
        end
        access(1'b0, 1'b1, 32'h02, 32'h12345678, ac, rd, er, st, rt);
        vectors++;
        if (ac !== 4 || er !== 1'b1) begin
            miscompares++; $display("FAIL err_misaligned_store: got cyc=%0d err=%b expected 4 1", ac, er);
        end
        access(1'b0, 1'b0, 32'h00, 32'h0, ac, rd, er, st, rt);
        vectors++;
        if (rd !== 32'h0BADF00D || er !== 1'b0) begin
            miscompares++; $display("FAIL err_store_suppressed: got %h err=%b expected 0badf00d 0", rd, er);
        end
        access(1'b0, 1'b0, 32'h400, 32'h0, ac, rd, er, st, rt);
        vectors++;
        if (ac !== 4 || er !== 1'b1 || rd !== 32'h0) begin
            miscompares++; $display("FAIL err_out_of_range: got cyc=%0d err=%b rdata=%h expected 4 1 00000000", ac, er, rd);
        end
        access(1'b0, 1'b0, 32'h3FC, 32'h0, ac, rd, er, st, rt);
        vectors++;
        if (ac !== 4 || er !== 1'b0) begin
            miscompares++; $display("FAIL err_last_word: got cyc=%0d err=%b expected 4 0", ac, er);
        end
    endtask

    task automatic test_back_to_back();
        int ac; logic [31:0] rd; logic er; logic [15:0] st, rt;
        logic [9:0]  ack_tr;
        logic [9:0]  rdy_tr;
        logic [31:0] rd4;
        logic [31:0] rd9;
        access(1'b0, 1'b1, 32'h04, 32'h44444444, ac, rd, er, st, rt);
        ack_tr = '0; rdy_tr = '0; rd4 = 32'h0; rd9 = 32'h0;
        drive(1'b0, 1'b1, 1'b0, 32'h0, 32'h0);
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            ack_tr[n] = bus4.ack_o;
            rdy_tr[n] = bus4.ready_o;
            if (n == 4) rd4 = bus4.rdata_o;
            if (n == 9) rd9 = bus4.rdata_o;
            @(posedge clk);
            #1;
            if (n == 4) drive(1'b0, 1'b1, 1'b0, 32'h4, 32'h0);
        end
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        vectors++;
        if (ack_tr !== 10'b10_0001_0000) begin
            miscompares++; $display("FAIL b2b_ack: got %b expected 1000010000", ack_tr);
        end
        vectors++;
        if (rdy_tr !== 10'b00_0010_0001) begin
            miscompares++; $display("FAIL b2b_ready: got %b expected 0000100001", rdy_tr);
        end
        vectors++;
        if (rd4 !== 32'h0BADF00D || rd9 !== 32'h44444444) begin
            miscompares++; $display("FAIL b2b_rdata: got %h %h expected 0badf00d 44444444", rd4, rd9);
        end
    endtask

    task automatic test_reset_mid_wait();
        int ac; logic [31:0] rd; logic er; logic [15:0] st, rt;
        logic seen_ack;
        access(1'b0, 1'b1, 32'h20, 32'hA5A50020, ac, rd, er, st, rt);
        seen_ack = 1'b0;
        drive(1'b0, 1'b1, 1'b1, 32'h20, 32'h55);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst = 1'b1;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus4.ack_o !== 1'b0) seen_ack = 1'b1;
            @(posedge clk);
            #1;
        end
        vectors++;
        if (seen_ack !== 1'b0) begin
            miscompares++; $display("FAIL rst_mid_ack: got ack=%b expected 0", seen_ack);
        end
        vectors++;
        if (bus4.ready_o !== 1'b1) begin
            miscompares++; $display("FAIL rst_mid_ready: got %b expected 1", bus4.ready_o);
        end
        access(1'b0, 1'b0, 32'h20, 32'h0, ac, rd, er, st, rt);
        vectors++;
        if (rd !== 32'hA5A50020) begin
            miscompares++; $display("FAIL rst_mid_no_write: got %h expected a5a50020", rd);
        end
    endtask

    task automatic test_latency1();
        int ac; logic [31:0] rd; logic er; logic [15:0] st, rt;
        access(1'b1, 1'b1, 32'h10, 32'h00001111, ac, rd, er, st, rt);
        vectors++;
        if (ac !== 1 || er !== 1'b0) begin
            miscompares++; $display("FAIL lat1_store: got cyc=%0d err=%b expected 1 0", ac, er);
        end
        access(1'b1, 1'b0, 32'h10, 32'h0, ac, rd, er, st, rt);
        vectors++;
        if (ac !== 1) begin miscompares++; $display("FAIL lat1_ack_cycle: got %0d expected 1", ac); end
        vectors++;
        if (rd !== 32'h00001111) begin
            miscompares++; $display("FAIL lat1_rdata: got %h expected 00001111", rd);
        end
        vectors++;
        if (st[1:0] !== 2'b01 || rt[1:0] !== 2'b01) begin
            miscompares++; $display("FAIL lat1_stall_ready: got stall=%b ready=%b expected 01 01", st[1:0], rt[1:0]);
        end
        access(1'b1, 1'b0, 32'h11, 32'h0, ac, rd, er, st, rt);
        vectors++;
        if (ac !== 1 || er !== 1'b1 || rd !== 32'h0) begin
            miscompares++; $display("FAIL lat1_err: got cyc=%0d err=%b rdata=%h expected 1 1 00000000", ac, er, rd);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        @(posedge clk);
        #1;
        test_reset();
        test_store_load();
        test_errors();
        test_back_to_back();
        test_reset_mid_wait();
        test_latency1();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
